rv_imm_gen_stage: RTL
=====================

// Module: rv_imm_gen_stage
// PURPOSE
//  Registered, XLEN-parametrised immediate-generation pipeline stage for the RV decode path.
//  Accepts {IR, PC} on a valid/ready handshake. One cycle later it presents:
//    - the sign-extended immediate
//    - its format code
//    - the PC-relative target (PC+imm)
//    - an illegal-opcode flag
//  Includes a 1-entry skid buffer, so in_ready does not depend combinationally on out_ready.
//  Sits between the fetch/IR register and the execute-operand mux.
// PARAMETERS
//  XLEN  32  datapath width, 32 or 64; imm/pc/target widths; XLEN=64 also decodes OP-IMM-32 (0011011)
//  SKID  1   1: skid buffer present, in_ready = !skid_valid; 0: in_ready = !out_valid | out_ready
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     sync kill of all held entries (branch redirect)
//  in_valid   in   1     input beat valid
//  in_ready   out  1     stage can accept a beat
//  in_ir      in   32    instruction word
//  in_pc      in   XLEN  PC of instruction
//  out_valid  out  1     output beat valid
//  out_ready  in   1     consumer accepts beat
//  out_ir     out  32    registered copy of in_ir
//  out_imm    out  XLEN  sign-extended immediate
//  out_fmt    out  3     0=R 1=I 2=S 3=B 4=U 5=J
//  out_tgt    out  XLEN  out_pc + out_imm, modulo 2^XLEN
//  out_tgt_ok out  1     1 for B, J, AUIPC (target meaningful); 0 otherwise (incl. JALR)
//  out_illegal out 1     opcode not in decode table
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, skid_valid=0, all data regs 0, out_fmt=0, flags 0.
//    in_ready=1 from the first edge after release.
//  Handshake: beats transfer on valid&&ready. out_* hold stable while out_valid && !out_ready.
//    in_valid may not be retracted by the producer; the stage does not rely on that.
//  Latency: 1 cycle accept->out_valid when the output register is empty or draining.
//    Throughput is 1 beat/cycle with out_ready held high.
//  Decode, on in_ir[6:0]; sign bit is IR[31], extended to XLEN:
//    I: 0010011, 0000011, 1100111, 1110011, 0001111; plus 0011011 iff XLEN=64
//       imm = sext(IR[31:20])
//    S: 0100011  imm = sext({IR[31:25], IR[11:7]})
//    B: 1100011  imm = sext({IR[31], IR[7], IR[30:25], IR[11:8], 1'b0})
//    U: 0110111, 0010111  imm = sext({IR[31:12], 12'b0})  (sign-extends above bit 31 when XLEN=64)
//    J: 1101111  imm = sext({IR[31], IR[19:12], IR[20], IR[30:21], 1'b0})
//    R: 0110011, 0111011(XLEN=64 only)  imm = 0
//    Other opcode: out_illegal=1, fmt=I, imm computed as I-type.
//  out_tgt is computed combinationally from in_pc+imm before registering.
//    Target register updates together with imm.
//  Skid (SKID=1):
//    - Input accepted while out_valid && !out_ready -> beat goes to skid, skid_valid=1, in_ready=0.
//    - Output consumed with skid_valid -> skid moves to output next cycle, skid_valid=0.
//    - Never more than 2 beats held; no beat dropped or duplicated.
//  Simultaneous out accept and in accept with skid empty: new beat loads the output register directly.
//  flush=1:
//    - out_valid and skid_valid cleared next edge.
//    - A beat presented the same cycle is discarded, even if the handshake completes.
//    - in_ready=1 in the cycle after flush.
//    - Data regs need not clear.
//  flush and reset mid-stall: all held beats dropped; nothing emitted afterwards.
// TESTING
//  1. XLEN=32, stream addi x1,x0,-1 (0xFFF00093) with out_ready=1:
//     out_imm=0xFFFFFFFF, fmt=1, out_valid one cycle after accept.
//  2. beq PC=0x100, imm=-8 (0xFE000CE3):
//     out_imm=0xFFFFFFF8, out_tgt=0x000000F8, out_tgt_ok=1.
//     jal 0x0040006F at PC=0x200: out_imm=4, out_tgt=0x204.
//  3. XLEN=64, lui 0x80000037:
//     out_imm=0xFFFFFFFF80000000.
//     Opcode 0011011 gives fmt=I, illegal=0; same opcode with XLEN=32 gives illegal=1.
//  4. out_ready=0 for 3 cycles while 3 beats offered:
//     beats 1-2 held (output+skid), in_ready=0 from cycle 2.
//     On release, order is 1,2,3 with no loss or duplication.
//  5. flush asserted with output+skid full and in_valid=1:
//     out_valid=0 next cycle, in_ready=1.
//     No discarded beat ever appears on the output.
//  6. rst_n pulsed low asynchronously mid-stall:
//     out_valid drops immediately, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/rv_imm_gen_stage.sv
// Registered RV immediate-generation stage: decodes {IR, PC} into immediate, format, PC-relative
// target and illegal flag, behind a valid/ready handshake with an optional 1-entry skid buffer.
module rv_imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_tgt,
    output logic            out_tgt_ok,
    output logic            out_illegal
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [31:0]     ir;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] tgt;
        logic            tgt_ok;
        logic            illegal;
    } beat_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam bit IS_RV64 = (XLEN == 64);

    logic               out_valid_q, out_valid_d;
    logic               skid_valid_q, skid_valid_d;
    beat_t              out_q, out_d;
    beat_t              skid_q, skid_d;
    beat_t              new_beat;
    fmt_e               dec_fmt;
    logic               dec_illegal;
    logic               dec_tgt_ok;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    dec_imm;
    logic               in_fire;

    // Opcode -> format classification; unknown opcodes decode as I-type and are flagged.
    always_comb begin
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
        dec_tgt_ok  = 1'b0;
        case (in_ir[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: dec_fmt = FMT_I;
            OPC_STORE:  dec_fmt = FMT_S;
            OPC_BRANCH: begin dec_fmt = FMT_B; dec_tgt_ok = 1'b1; end
            OPC_LUI:    dec_fmt = FMT_U;
            OPC_AUIPC:  begin dec_fmt = FMT_U; dec_tgt_ok = 1'b1; end
            OPC_JAL:    begin dec_fmt = FMT_J; dec_tgt_ok = 1'b1; end
            OPC_OP:     dec_fmt = FMT_R;
            OPC_OP_IMM_32: begin
                dec_fmt     = FMT_I;
                dec_illegal = !IS_RV64;
            end
            OPC_OP_32: begin
                dec_fmt     = IS_RV64 ? FMT_R : FMT_I;
                dec_illegal = !IS_RV64;
            end
            default:    dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I:   imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
            FMT_S:   imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
            FMT_B:   imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
            FMT_U:   imm32 = {in_ir[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Size cast of a signed operand sign-extends from bit 31 up to XLEN.
        dec_imm = XLEN'(imm32);

        new_beat.ir      = in_ir;
        new_beat.imm     = dec_imm;
        new_beat.fmt     = dec_fmt;
        new_beat.tgt     = in_pc + dec_imm;
        new_beat.tgt_ok  = dec_tgt_ok;
        new_beat.illegal = dec_illegal;
    end

    // With the skid present, in_ready is a pure register output; without it the stage is a plain
    // pipeline register whose ready looks through to the consumer.
    assign in_ready = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = new_beat;
                end
            end
        end else if (in_fire && SKID != 0) begin
            skid_d       = new_beat;
            skid_valid_d = 1'b1;
        end
        // A redirect drops everything held plus any beat arriving this cycle.
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values;
    // the data registers are reset too so all outputs read 0 during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ir      = out_q.ir;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_tgt     = out_q.tgt;
    assign out_tgt_ok  = out_q.tgt_ok;
    assign out_illegal = out_q.illegal;

endmodule
